// File: rtl/arp_pkg.sv
// ARP responder shared definitions: protocol constants, reply layout, FSM state type, CRC step.
// Latency: n/a (package). Backpressure: n/a.
// Contents: EtherType/ARP field constants, preamble/SFD bytes, CRC-32 init/residue, arp_state_e, arp_reply_t.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP     = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IP     = 16'h0800;
    localparam logic [7:0]  ARP_HLEN_ETH     = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IP      = 8'd4;
    localparam logic [15:0] ARP_OPER_REQ     = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
    localparam logic [1:0]  PKT_TYPE_ARP_REQ = 2'b01;
    localparam logic [7:0]  ETH_PREAMBLE     = 8'h55;
    localparam logic [7:0]  ETH_SFD          = 8'hD5;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE    = 32'hDEBB_20E3;
    localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB8_8320;
    // Ethernet header + ARP body, before zero padding.
    localparam logic [7:0]  ARP_HDR_BYTES    = 8'd42;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_PREAMBLE,
        S_SFD,
        S_PAYLOAD,
        S_FCS,
        S_IFG
    } arp_state_e;

    // Field order is wire order: the first declared field goes out first.
    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_reply_t;

    typedef logic [41:0][7:0] arp_reply_bytes_t;

    // One byte of reflected CRC-32, LSB of the data byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/arp_responder_if.sv
// Byte-wide MII-style tx bus with request/grant arbitration towards the tx mux.
// Latency: n/a (wiring). Backpressure: tx_gnt gates frame start only; once started a frame runs to the end.
// Signals: tx_req (own the bus), tx_gnt (bus granted), tx_data (byte), tx_en (byte valid).
interface arp_responder_if;
    logic       tx_req;
    logic       tx_gnt;
    logic [7:0] tx_data;
    logic       tx_en;

    modport master (output tx_req, output tx_data, output tx_en, input tx_gnt);
    modport slave  (input tx_req, input tx_data, input tx_en, output tx_gnt);
endinterface

// File: rtl/arp_responder_eth_crc32.sv
// eth_crc32: byte-wide Ethernet CRC-32 accumulator (reflected, combinational next, registered state).
// Latency: crc reflects a byte one cycle after en. Backpressure: none; en simply holds the value.
// Ports: clk, rst (sync, active-high), init (load CRC32_INIT), en (absorb data), data[7:0], crc[31:0] (raw, uncomplemented).
module eth_crc32
    import arp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, data);
        end
    end

endmodule

// File: rtl/arp_responder.sv
// arp_responder: answers ARP requests for the local IP with a full reply frame on the shared tx bus.
// Latency: tx_req the cycle after a matching strobe; first preamble byte the cycle after tx_gnt.
// Backpressure: waits in REQ for tx_gnt; one pending request is queued, further matches are dropped.
// Ports: clk, rst, i_local_mac/i_local_ip, i_req_* (parsed request strobe), tx (arp_responder_if.master),
//        o_busy, o_reply_cnt, o_drop_cnt. Define ARP_RESP_STATS_EN to build the reply/drop counters.
module arp_responder
    import arp_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [47:0]             i_local_mac,
    input  logic [31:0]             i_local_ip,
    input  logic                    i_req_vl,
    input  logic [1:0]              i_req_type,
    input  logic [47:0]             i_req_SHA,
    input  logic [31:0]             i_req_SPA,
    input  logic [31:0]             i_req_TPA,
    arp_responder_if.master         tx,
    output logic                    o_busy,
    output logic [7:0]              o_reply_cnt,
    output logic [7:0]              o_drop_cnt
);

    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] PAY_LAST  = 8'(MIN_FRAME - 1);
    localparam logic [7:0] FCS_LAST  = 8'd3;
    localparam logic [7:0] IFG_LAST  = 8'(IFG_CYCLES - 1);
    // With a request already queued, REQ is entered one cycle early so that REQ itself
    // supplies the final idle cycle and a granted frame follows exactly IFG_CYCLES later.
    localparam logic [7:0] IFG_EARLY = 8'(IFG_CYCLES - 2);

    arp_state_e       state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic             slot_full;
    logic [47:0]      slot_sha;
    logic [31:0]      slot_spa;
    logic [47:0]      fr_sha, fr_mac;
    logic [31:0]      fr_spa, fr_ip;
    logic             match, start, accept;
    arp_reply_t       reply;
    arp_reply_bytes_t reply_b;
    logic [7:0]       pay_byte;
    logic [31:0]      crc;

    assign match  = i_req_vl && (i_req_type == PKT_TYPE_ARP_REQ) &&
                    (i_req_TPA == i_local_ip) && (i_local_ip != 32'd0);
    assign start  = (state == S_REQ) && tx.tx_gnt;
    // The slot empties on the start edge, so a strobe on that same edge still fits.
    assign accept = match && (!slot_full || start);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            slot_full <= 1'b0;
            slot_sha  <= '0;
            slot_spa  <= '0;
            fr_sha    <= '0;
            fr_spa    <= '0;
            fr_mac    <= '0;
            fr_ip     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                slot_full <= 1'b1;
                slot_sha  <= i_req_SHA;
                slot_spa  <= i_req_SPA;
            end else if (start) begin
                slot_full <= 1'b0;
            end
            // Frame contents are frozen at start; later changes to local MAC/IP wait for the next frame.
            if (start) begin
                fr_sha <= slot_sha;
                fr_spa <= slot_spa;
                fr_mac <= i_local_mac;
                fr_ip  <= i_local_ip;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (slot_full || accept) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (tx.tx_gnt) begin
                    state_nxt = S_PREAMBLE;
                    cnt_nxt   = '0;
                end
            end
            S_PREAMBLE: begin
                if (cnt == PRE_LAST) begin
                    state_nxt = S_SFD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_SFD: begin
                state_nxt = S_PAYLOAD;
                cnt_nxt   = '0;
            end
            S_PAYLOAD: begin
                if (cnt == PAY_LAST) begin
                    state_nxt = S_FCS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_FCS: begin
                if (cnt == FCS_LAST) begin
                    state_nxt = S_IFG;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_IFG: begin
                if (slot_full && (cnt >= IFG_EARLY)) begin
                    state_nxt = S_REQ;
                end else if (cnt == IFG_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign reply = '{dst_mac:  fr_sha,
                     src_mac:  fr_mac,
                     eth_type: ETH_TYPE_ARP,
                     htype:    ARP_HTYPE_ETH,
                     ptype:    ARP_PTYPE_IP,
                     hlen:     ARP_HLEN_ETH,
                     plen:     ARP_PLEN_IP,
                     oper:     ARP_OPER_REPLY,
                     sha:      fr_mac,
                     spa:      fr_ip,
                     tha:      fr_sha,
                     tpa:      fr_spa};
    assign reply_b  = reply;
    // Byte 0 is the most significant byte of the packed reply; beyond the header the frame is zero pad.
    assign pay_byte = (cnt < ARP_HDR_BYTES) ? reply_b[6'd41 - cnt[5:0]] : 8'h00;

    eth_crc32 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (state == S_SFD),
        .en   (state == S_PAYLOAD),
        .data (pay_byte),
        .crc  (crc)
    );

    always_comb begin
        tx.tx_req  = 1'b0;
        tx.tx_en   = 1'b0;
        tx.tx_data = 8'h00;
        case (state)
            S_REQ: tx.tx_req = 1'b1;
            S_PREAMBLE: begin
                tx.tx_req  = 1'b1;
                tx.tx_en   = 1'b1;
                tx.tx_data = ETH_PREAMBLE;
            end
            S_SFD: begin
                tx.tx_req  = 1'b1;
                tx.tx_en   = 1'b1;
                tx.tx_data = ETH_SFD;
            end
            S_PAYLOAD: begin
                tx.tx_req  = 1'b1;
                tx.tx_en   = 1'b1;
                tx.tx_data = pay_byte;
            end
            S_FCS: begin
                tx.tx_req = 1'b1;
                tx.tx_en  = 1'b1;
                // FCS goes out complemented, least significant byte first.
                case (cnt[1:0])
                    2'd0:    tx.tx_data = ~crc[7:0];
                    2'd1:    tx.tx_data = ~crc[15:8];
                    2'd2:    tx.tx_data = ~crc[23:16];
                    default: tx.tx_data = ~crc[31:24];
                endcase
            end
            default: ;
        endcase
    end

    assign o_busy = (state != S_IDLE) || slot_full;

`ifdef ARP_RESP_STATS_EN
    logic [7:0] reply_cnt, drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            reply_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if ((state == S_FCS) && (cnt == FCS_LAST)) reply_cnt <= reply_cnt + 8'd1;
            if (match && !accept)                      drop_cnt  <= drop_cnt + 8'd1;
        end
    end

    assign o_reply_cnt = reply_cnt;
    assign o_drop_cnt  = drop_cnt;
`else
    assign o_reply_cnt = 8'd0;
    assign o_drop_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_arp_responder.sv
// Testbench for arp_responder: directed requests, a tx-mux grant model and a byte scoreboard.
// Expected frames are built from the request fields with an independent bit-serial CRC model.
module tb_arp_responder;

    localparam logic [47:0] MAC_A    = 48'h02_0A_0B_0C_0D_0E;
    localparam logic [47:0] MAC_B    = 48'h02_11_22_33_44_55;
    localparam logic [31:0] IP_US    = 32'hC0A8_010A;   // 192.168.1.10
    localparam logic [31:0] IP_OTHER = 32'hC0A8_010B;   // 192.168.1.11
    localparam logic [47:0] SHA_1    = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SHA_2    = 48'h02_00_00_00_00_02;
    localparam logic [47:0] SHA_3    = 48'h02_00_00_00_00_03;
    localparam logic [31:0] SPA_1    = 32'hC0A8_0164;
    localparam logic [31:0] SPA_2    = 32'hC0A8_0165;
`ifdef ARP_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] i_local_mac;
    logic [31:0] i_local_ip;
    logic        i_req_vl;
    logic [1:0]  i_req_type;
    logic [47:0] i_req_SHA;
    logic [31:0] i_req_SPA;
    logic [31:0] i_req_TPA;
    logic        o_busy;
    logic [7:0]  o_reply_cnt;
    logic [7:0]  o_drop_cnt;

    arp_responder_if txif ();

    arp_responder dut (
        .clk         (clk),
        .rst         (rst),
        .i_local_mac (i_local_mac),
        .i_local_ip  (i_local_ip),
        .i_req_vl    (i_req_vl),
        .i_req_type  (i_req_type),
        .i_req_SHA   (i_req_SHA),
        .i_req_SPA   (i_req_SPA),
        .i_req_TPA   (i_req_TPA),
        .tx          (txif),
        .o_busy      (o_busy),
        .o_reply_cnt (o_reply_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    int run_len = 0, idle_len = 0, last_len = 0, last_gap = 0;
    int frames_seen = 0, req_hi = 0, en_hi = 0;
    bit gnt_auto = 1'b1;
    bit gnt_manual = 1'b0;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Builds the expected reply frame byte by byte and queues it for the monitor.
    task automatic push_frame(input logic [47:0] sha, input logic [31:0] spa,
                              input logic [47:0] mac, input logic [31:0] ip);
        logic [7:0]  p [60];
        logic [31:0] c;
        logic        fb;
        for (int i = 0; i < 60; i++) p[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            p[i]      = 8'(sha >> (40 - 8 * i));
            p[6 + i]  = 8'(mac >> (40 - 8 * i));
            p[22 + i] = 8'(mac >> (40 - 8 * i));
            p[32 + i] = 8'(sha >> (40 - 8 * i));
        end
        for (int i = 0; i < 4; i++) begin
            p[28 + i] = 8'(ip >> (24 - 8 * i));
            p[38 + i] = 8'(spa >> (24 - 8 * i));
        end
        p[12] = 8'h08; p[13] = 8'h06; p[14] = 8'h00; p[15] = 8'h01;
        p[16] = 8'h08; p[17] = 8'h00; p[18] = 8'h06; p[19] = 8'h04;
        p[20] = 8'h00; p[21] = 8'h02;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ p[i][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 60; i++) exp_q.push_back(p[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(~8'(c >> (8 * i)));
    endtask

    task automatic send_req(input logic [1:0] typ, input logic [47:0] sha,
                            input logic [31:0] spa, input logic [31:0] tpa);
        @(negedge clk);
        i_req_vl   = 1'b1;
        i_req_type = typ;
        i_req_SHA  = sha;
        i_req_SPA  = spa;
        i_req_TPA  = tpa;
        @(negedge clk);
        i_req_vl   = 1'b0;
    endtask

    task automatic wait_en(input int budget, input string tag);
        int n;
        n = 0;
        while (!txif.tx_en && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(64'(txif.tx_en), 64'd1, tag);
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(64'(frames_seen), 64'(target), tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Tx mux model: grants whenever the responder requests, unless the bench takes manual control.
    initial begin
        txif.tx_gnt = 1'b0;
        forever begin
            @(negedge clk);
            txif.tx_gnt = gnt_auto ? txif.tx_req : gnt_manual;
        end
    end

    // Monitor: pops the scoreboard on every tx_en byte, measures frame lengths and idle gaps.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (txif.tx_req) req_hi++;
            if (txif.tx_en) begin
                en_hi++;
                if (run_len == 0) last_gap = idle_len;
                run_len++;
                idle_len = 0;
                if (exp_q.size() == 0) chk(64'(txif.tx_en), 64'd0, "unexpected_tx_byte");
                else                   chk(64'(txif.tx_data), 64'(exp_q.pop_front()), "tx_byte");
            end else begin
                if (run_len != 0) begin
                    last_len = run_len;
                    frames_seen++;
                    run_len = 0;
                end
                idle_len++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, r0, e0;
        rst         = 1'b1;
        i_local_mac = MAC_A;
        i_local_ip  = IP_US;
        i_req_vl    = 1'b0;
        i_req_type  = 2'b00;
        i_req_SHA   = '0;
        i_req_SPA   = '0;
        i_req_TPA   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk(64'(txif.tx_req), 64'd0, "rst_tx_req");
        chk(64'(txif.tx_en),  64'd0, "rst_tx_en");
        chk(64'(o_busy),      64'd0, "rst_busy");
        chk(64'(o_reply_cnt), 64'd0, "rst_reply_cnt");
        chk(64'(o_drop_cnt),  64'd0, "rst_drop_cnt");
        rst = 1'b0;
        @(negedge clk);

        // Basic reply; local MAC/IP changed mid-frame must not leak into the frame
        f0 = frames_seen;
        push_frame(SHA_1, SPA_1, MAC_A, IP_US);
        send_req(2'b01, SHA_1, SPA_1, IP_US);
        chk(64'(txif.tx_req), 64'd1, "req_cycle_after_strobe");
        chk(64'(o_busy),      64'd1, "busy_pending");
        wait_en(10, "frame1_start");
        i_local_mac = MAC_B;
        i_local_ip  = IP_OTHER;
        wait_frames(f0 + 1, 200, "frame1_done");
        chk(64'(last_len), 64'd72, "frame1_len");
        chk(64'(exp_q.size()), 64'd0, "frame1_all_bytes");
        i_local_mac = MAC_A;
        i_local_ip  = IP_US;
        repeat (14) @(negedge clk);
        chk(64'(o_busy),      64'd0, "idle_after_ifg");
        chk(64'(o_reply_cnt), STATS ? 64'd1 : 64'd0, "reply_cnt_1");

        // Non-matching requests are ignored
        r0 = req_hi;
        e0 = en_hi;
        send_req(2'b01, SHA_2, SPA_2, IP_OTHER);
        send_req(2'b10, SHA_2, SPA_2, IP_US);
        i_local_ip = 32'd0;
        send_req(2'b01, SHA_2, SPA_2, 32'd0);
        repeat (30) @(negedge clk);
        i_local_ip = IP_US;
        chk(64'(req_hi - r0), 64'd0, "nomatch_req");
        chk(64'(en_hi - e0),  64'd0, "nomatch_en");
        chk(64'(o_busy),      64'd0, "nomatch_busy");
        chk(64'(o_reply_cnt), STATS ? 64'd1 : 64'd0, "nomatch_reply_cnt");
        chk(64'(o_drop_cnt),  64'd0, "nomatch_drop_cnt");

        // Grant withheld for 20 cycles
        gnt_auto   = 1'b0;
        gnt_manual = 1'b0;
        f0 = frames_seen;
        push_frame(SHA_2, SPA_2, MAC_A, IP_US);
        send_req(2'b01, SHA_2, SPA_2, IP_US);
        r0 = req_hi;
        e0 = en_hi;
        repeat (20) @(negedge clk);
        chk(64'(req_hi - r0), 64'd20, "nognt_req_held");
        chk(64'(en_hi - e0),  64'd0,  "nognt_no_en");
        @(posedge clk);
        #2;
        gnt_manual = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(64'(txif.tx_en),   64'd1,  "en_cycle_after_gnt");
        chk(64'(txif.tx_data), 64'h55, "first_preamble_byte");
        wait_frames(f0 + 1, 200, "frame_gnt_done");
        gnt_auto   = 1'b1;
        gnt_manual = 1'b0;
        chk(64'(last_len), 64'd72, "frame_gnt_len");
        repeat (14) @(negedge clk);

        // Queued request follows after exactly 12 idle cycles; third match is dropped
        do_reset();
        f0 = frames_seen;
        push_frame(SHA_1, SPA_1, MAC_A, IP_US);
        send_req(2'b01, SHA_1, SPA_1, IP_US);
        wait_en(10, "b2b_first_start");
        push_frame(SHA_2, SPA_2, MAC_A, IP_US);
        send_req(2'b01, SHA_2, SPA_2, IP_US);
        send_req(2'b01, SHA_3, SPA_2, IP_US);
        wait_frames(f0 + 2, 400, "b2b_both_done");
        chk(64'(last_gap), 64'd12, "b2b_gap");
        chk(64'(last_len), 64'd72, "b2b_second_len");
        repeat (60) @(negedge clk);
        chk(64'(frames_seen - f0), 64'd2, "b2b_no_third_frame");
        chk(64'(exp_q.size()),     64'd0, "b2b_all_bytes");
        chk(64'(o_reply_cnt), STATS ? 64'd2 : 64'd0, "b2b_reply_cnt");
        chk(64'(o_drop_cnt),  STATS ? 64'd1 : 64'd0, "b2b_drop_cnt");

        // Reset at payload byte 30
        push_frame(SHA_1, SPA_1, MAC_A, IP_US);
        send_req(2'b01, SHA_1, SPA_1, IP_US);
        wait_en(10, "rstmid_start");
        repeat (38) @(negedge clk);
        chk(64'(txif.tx_data), 64'h01, "rstmid_payload_byte30");
        rst = 1'b1;
        @(negedge clk);
        chk(64'(txif.tx_en),  64'd0, "rstmid_en");
        chk(64'(txif.tx_req), 64'd0, "rstmid_req");
        chk(64'(o_busy),      64'd0, "rstmid_busy");
        rst = 1'b0;
        exp_q.delete();
        e0 = en_hi;
        repeat (100) @(negedge clk);
        chk(64'(en_hi - e0),  64'd0, "rstmid_no_resume");
        chk(64'(o_busy),      64'd0, "rstmid_idle");
        chk(64'(o_reply_cnt), 64'd0, "rstmid_reply_cnt");

        // 256 replies: counter wraps
        f0 = frames_seen;
        for (int i = 0; i < 256; i++) begin
            push_frame(SHA_2, SPA_1, MAC_A, IP_US);
            send_req(2'b01, SHA_2, SPA_1, IP_US);
            wait_frames(f0 + i + 1, 200, "wrap_frame");
            if (i == 254) chk(64'(o_reply_cnt), STATS ? 64'd255 : 64'd0, "reply_cnt_255");
        end
        repeat (14) @(negedge clk);
        chk(64'(o_reply_cnt), 64'd0, "reply_cnt_wrap");
        chk(64'(o_drop_cnt),  64'd0, "wrap_drop_cnt");
        chk(64'(exp_q.size()), 64'd0, "wrap_all_bytes");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
